// File: rtl/intr_ctrl_gen_pkg.sv
// Shared types and defaults for the parametrised interrupt aggregator.
// The trigger type and control word are common to the top and the pulse generator.
package intr_ctrl_gen_pkg;

  typedef enum logic {
    INTR_LEVEL_TRIG = 1'b0,
    INTR_PULSE_TRIG = 1'b1
  } intr_trigger_type;

  localparam int PW_BW_DEFAULT = 8;
  localparam int PW_DEFAULT    = 10;

  typedef struct packed {
    logic [PW_BW_DEFAULT-1:0] width;
    intr_trigger_type         trig_type;
  } intr_ctrl_t;

  localparam intr_ctrl_t INTR_CTRL_DEFAULT = '{
    width:     PW_BW_DEFAULT'(PW_DEFAULT),
    trig_type: INTR_PULSE_TRIG
  };

  // Pulse length actually loaded: a zero width still produces a single cycle.
  function automatic logic [PW_BW_DEFAULT-1:0] pulse_load(input logic [PW_BW_DEFAULT-1:0] width);
    if (width == {PW_BW_DEFAULT{1'b0}}) begin
      return {{(PW_BW_DEFAULT-1){1'b0}}, 1'b1};
    end else begin
      return width;
    end
  endfunction

endpackage

// File: rtl/intr_pulse_gen.sv
// Interrupt line generator: level follow-through or a reloadable pulse counter.
// A mode change forces one quiet cycle so nothing carries over between modes.
module intr_pulse_gen
  import intr_ctrl_gen_pkg::*;
#(
  parameter int PW_BW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             level,
  input  logic             mode,
  input  logic [PW_BW-1:0] width,
  input  logic             mode_chg,
  output logic             intr
);

  logic [PW_BW-1:0] cnt_r;
  logic [PW_BW-1:0] cnt_n;
  logic [PW_BW-1:0] load_s;
  logic             intr_r;
  logic             intr_n;

  assign load_s = (width == {PW_BW{1'b0}}) ? {{(PW_BW-1){1'b0}}, 1'b1} : width;

  // State register: pulse counter and registered interrupt line.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {PW_BW{1'b0}};
      intr_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_n;
      intr_r <= intr_n;
    end
  end

  // Next-state: a fresh trigger reloads, otherwise count down to idle.
  always_comb begin
    cnt_n = cnt_r;
    if (mode_chg) begin
      cnt_n = {PW_BW{1'b0}};
    end else if (mode == INTR_PULSE_TRIG) begin
      if (trig) begin
        cnt_n = load_s;
      end else if (cnt_r != {PW_BW{1'b0}}) begin
        cnt_n = cnt_r - {{(PW_BW-1){1'b0}}, 1'b1};
      end else begin
        cnt_n = {PW_BW{1'b0}};
      end
    end else begin
      cnt_n = {PW_BW{1'b0}};
    end
  end

  // Output: level mode mirrors masked status, pulse mode is high while counting.
  always_comb begin
    intr_n = 1'b0;
    if (mode_chg) begin
      intr_n = 1'b0;
    end else if (mode == INTR_PULSE_TRIG) begin
      intr_n = (cnt_n != {PW_BW{1'b0}});
    end else begin
      intr_n = level;
    end
  end

  assign intr = intr_r;

endmodule

// File: rtl/intr_ctrl_gen.sv
// Parametrised interrupt aggregator: sticky raw status with W1C, mask, NMI bypass, one CPU line.
// Optional macro INTR_CTRL_GEN_SYNC_EN adds a 2-flop synchroniser in front of the edge detector.
module intr_ctrl_gen
  import intr_ctrl_gen_pkg::*;
#(
  parameter int                NUM_SRC       = 8,
  parameter int                PW_BW         = 8,
  parameter int                PW_DEFAULT    = intr_ctrl_gen_pkg::PW_DEFAULT,
  parameter logic [NUM_SRC-1:0] NMI_MASK      = {NUM_SRC{1'b0}},
  parameter logic [NUM_SRC-1:0] INIT_CLR_MASK = {NUM_SRC{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               w1c_vld,
  input  logic [NUM_SRC-1:0] w1c_data,
  input  logic               msk_we,
  input  logic [NUM_SRC-1:0] msk_wdata,
  input  logic               ctrl_we,
  input  logic               ctrl_type,
  input  logic [PW_BW-1:0]   ctrl_width,
  input  logic               init_clr,
  output logic [NUM_SRC-1:0] raw_stat,
  output logic [NUM_SRC-1:0] msk_stat,
  output logic [NUM_SRC-1:0] msk,
  output logic               intr
);

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_q_r;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] en_s;
  logic [NUM_SRC-1:0] raw_r;
  logic [NUM_SRC-1:0] msk_r;
  intr_trigger_type   ctrl_type_r;
  logic [PW_BW-1:0]   ctrl_width_r;
  logic               trig_s;
  logic               level_s;

`ifdef INTR_CTRL_GEN_SYNC_EN
  logic [NUM_SRC-1:0] sync1_r;
  logic [NUM_SRC-1:0] sync2_r;

  // Two-flop synchroniser for sources from foreign clock domains.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {NUM_SRC{1'b0}};
      sync2_r <= {NUM_SRC{1'b0}};
    end else begin
      sync1_r <= src;
      sync2_r <= sync1_r;
    end
  end

  assign src_s = sync2_r;
`else
  assign src_s = src;
`endif

  // Source history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q_r <= {NUM_SRC{1'b0}};
    end else begin
      src_q_r <= src_s;
    end
  end

  // Edge, clear and enable terms; NMI sources bypass the mask everywhere.
  always_comb begin
    en_s    = msk_r | NMI_MASK;
    rise_s  = src_s & ~src_q_r;
    clr_s   = (w1c_vld  ? w1c_data      : {NUM_SRC{1'b0}})
            | (init_clr ? INIT_CLR_MASK : {NUM_SRC{1'b0}});
    trig_s  = |(rise_s & en_s);
    level_s = |(raw_r & en_s);
  end

  // Sticky raw status; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_r <= {NUM_SRC{1'b0}};
    end else begin
      raw_r <= rise_s | (raw_r & ~clr_s);
    end
  end

  // Mask and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      msk_r        <= {NUM_SRC{1'b0}};
      ctrl_type_r  <= INTR_PULSE_TRIG;
      ctrl_width_r <= PW_BW'(PW_DEFAULT);
    end else begin
      if (msk_we) begin
        msk_r <= msk_wdata;
      end
      if (ctrl_we) begin
        ctrl_type_r  <= intr_trigger_type'(ctrl_type);
        ctrl_width_r <= ctrl_width;
      end
    end
  end

  intr_pulse_gen #(
    .PW_BW (PW_BW)
  ) u_pulse_gen (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig_s),
    .level    (level_s),
    .mode     (ctrl_type_r),
    .width    (ctrl_width_r),
    .mode_chg (ctrl_we),
    .intr     (intr)
  );

  assign raw_stat = raw_r;
  assign msk      = msk_r;
  assign msk_stat = raw_r & en_s;

endmodule

// File: tb/tb_intr_ctrl_gen.sv
// Self-checking bench for intr_ctrl_gen: directed scenarios with literal expectations,
// then random traffic checked every cycle against a deadline-based behavioural model.
module tb_intr_ctrl_gen;

  localparam int         N   = 8;
  localparam int         PWB = 8;
  localparam logic [7:0] NMI = 8'h80;
  localparam logic [7:0] ICM = 8'h0F;
`ifdef INTR_CTRL_GEN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src;
  logic           w1c_vld;
  logic [N-1:0]   w1c_data;
  logic           msk_we;
  logic [N-1:0]   msk_wdata;
  logic           ctrl_we;
  logic           ctrl_type;
  logic [PWB-1:0] ctrl_width;
  logic           init_clr;
  logic [N-1:0]   raw_stat;
  logic [N-1:0]   msk_stat;
  logic [N-1:0]   msk;
  logic           intr;

  int n_assert = 0;
  int n_fail   = 0;

  intr_ctrl_gen #(
    .NUM_SRC       (N),
    .PW_BW         (PWB),
    .PW_DEFAULT    (10),
    .NMI_MASK      (NMI),
    .INIT_CLR_MASK (ICM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .w1c_vld    (w1c_vld),
    .w1c_data   (w1c_data),
    .msk_we     (msk_we),
    .msk_wdata  (msk_wdata),
    .ctrl_we    (ctrl_we),
    .ctrl_type  (ctrl_type),
    .ctrl_width (ctrl_width),
    .init_clr   (init_clr),
    .raw_stat   (raw_stat),
    .msk_stat   (msk_stat),
    .msk        (msk),
    .intr       (intr)
  );

  always #5 clk = ~clk;

  // Behavioural model: a pulse is a deadline (edge index until which intr is high).
  bit         m_valid = 1'b0;
  logic [7:0] m_raw = 8'h00, m_msk = 8'h00, m_prev = 8'h00, m_d1 = 8'h00, m_d2 = 8'h00;
  bit         m_mode = 1'b1;
  int         m_width = 10;
  int         edge_n = 0;
  int         pulse_until = 0;
  bit         m_intr = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] eff, rise, en, clr;
    int w;
    eff = (LAT == 3) ? m_d2 : src;
    edge_n = edge_n + 1;
    if (rst) begin
      m_valid = 1'b1;
      m_raw = 8'h00; m_msk = 8'h00; m_prev = 8'h00; m_d1 = 8'h00; m_d2 = 8'h00;
      m_mode = 1'b1; m_width = 10; pulse_until = 0; m_intr = 1'b0;
    end else begin
      en   = m_msk | NMI;
      rise = eff & ~m_prev;
      if (ctrl_we) begin
        m_intr = 1'b0;
        pulse_until = 0;
      end else if (!m_mode) begin
        m_intr = |(m_raw & en);
      end else begin
        if (|(rise & en)) begin
          w = (m_width == 0) ? 1 : m_width;
          pulse_until = edge_n + w;
        end
        m_intr = (edge_n < pulse_until);
      end
      clr = (w1c_vld ? w1c_data : 8'h00) | (init_clr ? ICM : 8'h00);
      m_raw = rise | (m_raw & ~clr);
      if (msk_we) m_msk = msk_wdata;
      if (ctrl_we) begin
        m_mode  = ctrl_type;
        m_width = int'(ctrl_width);
      end
      m_prev = eff;
      m_d2 = m_d1;
      m_d1 = src;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_raw_stat", {24'h0, raw_stat}, {24'h0, m_raw});
      check("model_msk",      {24'h0, msk},      {24'h0, m_msk});
      check("model_msk_stat", {24'h0, msk_stat}, {24'h0, m_raw & (m_msk | NMI)});
      check("model_intr",     {31'h0, intr},     {31'h0, m_intr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_msk(input logic [7:0] m);
    msk_we = 1'b1; msk_wdata = m;
    tick();
    msk_we = 1'b0;
  endtask

  task automatic wr_ctrl(input logic t, input logic [7:0] w);
    ctrl_we = 1'b1; ctrl_type = t; ctrl_width = w;
    tick();
    ctrl_we = 1'b0;
  endtask

  task automatic w1c(input logic [7:0] d);
    w1c_vld = 1'b1; w1c_data = d;
    tick();
    w1c_vld = 1'b0;
  endtask

  // Raise src[a] at cycle 0 and src[b] at cycle gap (b<0: none), count intr-high cycles.
  task automatic pulse_run(input int a, input int b, input int gap, output int hi);
    hi = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) src[a] = 1'b1;
      if (b >= 0 && i == gap) src[b] = 1'b1;
      tick();
      if (intr) hi++;
    end
  endtask

  initial begin
    int lat, hi;
    rst = 1'b1; src = 8'h00; w1c_vld = 1'b0; w1c_data = 8'h00; msk_we = 1'b0;
    msk_wdata = 8'h00; ctrl_we = 1'b0; ctrl_type = 1'b0; ctrl_width = 8'h00; init_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_raw", {24'h0, raw_stat}, 32'h0);
    check("reset_msk", {24'h0, msk}, 32'h0);
    check("reset_msk_stat", {24'h0, msk_stat}, 32'h0);
    check("reset_intr", {31'h0, intr}, 32'h0);

    // Default pulse mode, width 10.
    wr_msk(8'h08);
    src[3] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (raw_stat[3] !== 1'b1 && lat < 10);
    check("src_to_raw_latency", lat, LAT);
    check("raw_after_src3", {24'h0, raw_stat}, 32'h08);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (intr) hi++;
      tick();
    end
    check("default_pulse_width", hi, 10);

    // Masked-off event, unmask without pulse, then level mode.
    w1c_vld = 1'b1; w1c_data = 8'hFF; msk_we = 1'b1; msk_wdata = 8'h00;
    tick();
    w1c_vld = 1'b0; msk_we = 1'b0;
    src[2] = 1'b1;
    repeat (LAT + 1) tick();
    check("raw_src2_masked", {24'h0, raw_stat}, 32'h04);
    check("msk_stat_masked", {24'h0, msk_stat}, 32'h0);
    check("intr_masked", {31'h0, intr}, 32'h0);
    wr_msk(8'h04);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (intr) hi++;
      tick();
    end
    check("no_pulse_on_unmask", hi, 0);
    wr_ctrl(1'b0, 8'd10);
    check("mode_change_quiet", {31'h0, intr}, 32'h0);
    tick();
    check("level_intr_high", {31'h0, intr}, 32'h1);
    w1c(8'h04);
    check("w1c_clears_raw", {24'h0, raw_stat}, 32'h0);
    tick();
    check("level_intr_low", {31'h0, intr}, 32'h0);

    // Set wins over same-cycle clear.
    wr_ctrl(1'b1, 8'd4);
    src[0] = 1'b1;
    repeat (LAT - 1) tick();
    w1c_vld = 1'b1; w1c_data = 8'h01;
    tick();
    w1c_vld = 1'b0;
    check("set_wins_over_clear", {31'h0, raw_stat[0]}, 32'h1);

    // Pulse extension and zero width.
    wr_msk(8'h30);
    pulse_run(4, 5, 2, hi);
    check("pulse_extended", hi, 6);
    wr_ctrl(1'b1, 8'd0);
    wr_msk(8'h40);
    pulse_run(6, -1, 0, hi);
    check("width_zero_pulse", hi, 1);

    // NMI source ignores the mask.
    wr_ctrl(1'b1, 8'd3);
    wr_msk(8'h00);
    pulse_run(7, -1, 0, hi);
    check("nmi_pulse", hi, 3);
    check("nmi_msk_stat", {24'h0, msk_stat}, 32'h80);

    // init_clr only clears the low nibble.
    src = 8'h00;
    repeat (LAT + 1) tick();
    src = 8'hFF;
    repeat (LAT + 1) tick();
    check("raw_all_set", {24'h0, raw_stat}, 32'hFF);
    init_clr = 1'b1;
    tick();
    init_clr = 1'b0;
    check("init_clr", {24'h0, raw_stat}, 32'hF0);

    // Reset during an active pulse.
    wr_ctrl(1'b1, 8'd10);
    wr_msk(8'h02);
    src = 8'h00;
    repeat (LAT + 1) tick();
    src[1] = 1'b1;
    repeat (LAT) tick();
    repeat (5) tick();
    check("pulse_active_before_rst", {31'h0, intr}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_pulse_intr", {31'h0, intr}, 32'h0);
    check("rst_mid_pulse_raw", {24'h0, raw_stat}, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      src        = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      w1c_vld    = ($urandom_range(0, 7) == 0);
      w1c_data   = 8'($urandom);
      msk_we     = ($urandom_range(0, 7) == 0);
      msk_wdata  = 8'($urandom);
      ctrl_we    = ($urandom_range(0, 15) == 0);
      ctrl_type  = 1'($urandom);
      ctrl_width = 8'($urandom_range(0, 6));
      init_clr   = ($urandom_range(0, 31) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; w1c_vld = 1'b0; msk_we = 1'b0; ctrl_we = 1'b0; init_clr = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl_gen.md
Name: intr_ctrl_gen

Overview:
- Parametrised interrupt aggregator; next generation of the fixed two-source RAW_INTR_STAT/INTR_MSK/INTR_CTRL register group.
- Captures NUM_SRC source events into sticky raw status bits with W1C clear, masks them, and drives one CPU interrupt line.
- Output mode is level or pulse, with a programmable pulse width.
- Sits between peripheral event sources and the regbank write/read path.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32)
- PW_BW, 8, bit width of the pulse-width field
- PW_DEFAULT, 10, reset value of the pulse width
- NMI_MASK, '0 (NUM_SRC bits), sources that ignore the mask (non-maskable)
- INIT_CLR_MASK, '1 (NUM_SRC bits), sources cleared by init_clr

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- src  in  NUM_SRC  source event levels; a rising edge sets the raw bit
- w1c_vld  in  1  write-1-to-clear strobe for raw status
- w1c_data  in  NUM_SRC  bits to clear
- msk_we  in  1  mask register write enable
- msk_wdata  in  NUM_SRC  new mask (1 = enabled)
- ctrl_we  in  1  control write enable
- ctrl_type  in  1  trigger type (intr_trigger_type): 0 = level, 1 = pulse
- ctrl_width  in  PW_BW  pulse width in cycles
- init_clr  in  1  clears raw bits selected by INIT_CLR_MASK
- raw_stat  out  NUM_SRC  raw status register
- msk_stat  out  NUM_SRC  masked status (raw & (mask | NMI_MASK)), combinational from registers
- msk  out  NUM_SRC  mask register
- intr  out  1  interrupt line

Behaviour:
- Reset values:
  - raw_stat, src history register, intr, pulse counter: 0
  - msk: 0
  - type: pulse
  - width: PW_DEFAULT
- Edge detect: rise = src & ~src_q, where src_q is registered src. Sets raw bit on the next clk edge (1 cycle latency src→raw_stat).
- Raw update per bit: raw_n = rise | (raw & ~clr).
  - clr = (w1c_vld ? w1c_data : 0) | (init_clr ? INIT_CLR_MASK : 0).
  - A set in the same cycle as a clear wins (event never lost).
- msk/ctrl writes take effect next cycle. Simultaneous msk_we and w1c_vld are independent.
- Level mode: intr registered = |msk_stat; 1 cycle after raw_stat/msk change.
- Pulse mode, per-cycle trigger:
  - new = |(rise & (msk | NMI_MASK)), i.e. a fresh masked event, not a steady status.
  - On new, load cnt = max(width,1); intr = 1 while cnt != 0; decrement each cycle.
  - new during an active pulse reloads cnt, so the pulse extends.
  - width 0 behaves as 1.
  - Unmasking an already-set raw bit does NOT trigger a pulse.
- Mode change (ctrl_we) clears cnt and intr for one cycle, then the new mode applies. No glitch carryover.
- Reset mid-pulse: intr 0 on the next edge; counter cleared.
- NMI bits ignore msk in both msk_stat and the trigger.

Optional Feature:
- Macro: INTR_CTRL_GEN_SYNC_EN.
- Defined: src passes through a 2-flop synchroniser before the edge detector. Latency src→raw_stat becomes 3 cycles; synchroniser flops reset to 0.
- Undefined: src is assumed synchronous to clk; latency is 1 cycle.

Decomposition:
- Shared package IntrGen, holding:
  - typedef enum logic {INTR_LEVEL_TRIG, INTR_PULSE_TRIG} intr_trigger_type
  - packed struct intr_ctrl_t {logic [PW_BW-1:0] width; intr_trigger_type type;}
  - default constants PW_DEFAULT and INTR_CTRL_DEFAULT
- Sub-module intr_pulse_gen (trigger, width → intr): owns the counter and the level/pulse mux.

Test Plan:
- Reset, then src[3] 0→1 with msk=8'h08, pulse mode, width=10 → raw_stat=8'h08 after 1 cycle; intr high exactly 10 cycles.
- src[2] rises while msk=0 → raw_stat=8'h04, msk_stat=0, intr stays 0. Then write msk=8'h04 → in pulse mode no pulse; switch to level mode → intr=1 one cycle after the mode write. Then w1c_data=8'h04 → intr=0 next cycle.
- Same-cycle src[0] rise and w1c_vld with w1c_data=8'h01 → raw_stat[0]=1 afterwards.
- Pulse width 4, second masked event 2 cycles into the pulse → intr high 6 cycles total. Width 0 → 1-cycle pulse.
- NMI_MASK=8'h80, msk=0, src[7] rises → msk_stat=8'h80 and a pulse occurs. init_clr with INIT_CLR_MASK=8'h0F and raw=8'hFF → raw=8'hF0.
- rst asserted during an active pulse (cnt=5) → intr=0 and raw_stat=0 next edge. With INTR_CTRL_GEN_SYNC_EN defined, src→raw latency measured at 3 cycles.
